instr_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer between the program counter and the instruction memory. It owns the PC and drives the word address into instruction memory, whose read data returns combinationally in the same cycle. It also maintains the IF/ID pipeline register. It handles start/halt sequencing, hazard-unit stalls, branch redirects with flush, and end-of-program detection.

---
 rtl/instr_fetch_ctrl.sv | 111 +++++++++++
 tb/tb_instr_fetch_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives instruction-memory address,
// and maintains the IF/ID pipeline register with stall, branch flush and end detection.
module instr_fetch_ctrl #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LAST_ADDR = 128,
  parameter logic [31:0] NOP_WORD  = 32'h8000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data,
  output logic [31:0]       ifid_instr,
  output logic [ADDR_W-1:0] ifid_npc,
  output logic              ifid_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  issued
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] npc_q, npc_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  issued_q, issued_d;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    npc_d    = npc_q;
    valid_d  = valid_q;
    issued_d = issued_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_RUN;
          pc_d     = '0;
          issued_d = '0;
        end
      end
      S_RUN: begin
        // Branch flush outranks stall; out-of-range PC never indexes memory.
        if (br_taken) begin
          pc_d    = br_target;
          instr_d = NOP_WORD;
          npc_d   = '0;
          valid_d = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (pc_q > LAST) begin
          state_d = S_DONE;
          instr_d = NOP_WORD;
          npc_d   = '0;
          valid_d = 1'b0;
        end else begin
          instr_d = mem_data;
          npc_d   = pc_q + 1'b1;
          valid_d = 1'b1;
          pc_d    = pc_q + 1'b1;
          if (issued_q != '1) issued_d = issued_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      instr_q  <= NOP_WORD;
      npc_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      npc_q    <= npc_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      issued_q <= issued_d;
    end
  end

  assign mem_addr   = pc_q;
  assign ifid_instr = instr_q;
  assign ifid_npc   = npc_q;
  assign ifid_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign issued     = issued_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: driver pushes reference-model expectations,
// monitor pops and compares one cycle-worth of outputs after each rising edge.
module tb_instr_fetch_ctrl;

  localparam int          AW    = 8;
  localparam int          LAST  = 7;
  localparam int          CW    = 4;
  localparam logic [31:0] NOP   = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst_n, start, stall, br_taken;
  logic [AW-1:0] br_target, mem_addr, ifid_npc;
  logic [31:0]   mem_data, ifid_instr;
  logic          ifid_valid, busy, done;
  logic [CW-1:0] issued;

  logic [31:0] mem [0:LAST];

  instr_fetch_ctrl #(.ADDR_W(AW), .LAST_ADDR(LAST), .NOP_WORD(NOP), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .mem_addr(mem_addr), .mem_data(mem_data),
    .ifid_instr(ifid_instr), .ifid_npc(ifid_npc), .ifid_valid(ifid_valid),
    .busy(busy), .done(done), .issued(issued)
  );

  always #5 clk = ~clk;

  // Beyond the last word the memory returns junk, which must never be fetched.
  assign mem_data = (int'(mem_addr) <= LAST) ? mem[mem_addr] : (32'hBAD0_0000 | 32'(mem_addr));

  typedef struct packed {
    logic          busy, done, valid;
    logic [31:0]   instr;
    logic [AW-1:0] npc, pc;
    logic [CW-1:0] issued;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: mode 0=idle, 1=running, 2=finished.
  int          m_mode;
  int          m_pc;
  logic [31:0] m_instr;
  int          m_npc;
  bit          m_valid;
  int          m_issued;

  function automatic obs_t model_obs();
    obs_t o;
    o.busy   = (m_mode == 1);
    o.done   = (m_mode == 2);
    o.valid  = m_valid;
    o.instr  = m_instr;
    o.npc    = AW'(m_npc);
    o.pc     = AW'(m_pc);
    o.issued = CW'(m_issued);
    return o;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_instr = NOP; m_npc = 0; m_valid = 0; m_issued = 0;
  endtask

  task automatic model_step(input bit r, input bit s, input bit st, input bit b, input int t);
    if (!r) begin
      model_reset();
      return;
    end
    if (m_mode != 1) begin
      if (s) begin m_mode = 1; m_pc = 0; m_issued = 0; end
    end else if (b) begin
      m_pc = t; m_instr = NOP; m_npc = 0; m_valid = 0;
    end else if (st) begin
      // everything holds
    end else if (m_pc > LAST) begin
      m_mode = 2; m_instr = NOP; m_npc = 0; m_valid = 0;
    end else begin
      m_instr  = mem[m_pc];
      m_npc    = (m_pc + 1) % (1 << AW);
      m_valid  = 1;
      m_pc     = (m_pc + 1) % (1 << AW);
      m_issued = (m_issued + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_issued + 1;
    end
  endtask

  function automatic obs_t dut_obs();
    obs_t o;
    o.busy = busy; o.done = done; o.valid = ifid_valid; o.instr = ifid_instr;
    o.npc = ifid_npc; o.pc = mem_addr; o.issued = issued;
    return o;
  endfunction

  task automatic compare(input string name, input obs_t act, input obs_t e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s t=%0t: got busy=%b done=%b valid=%b instr=%h npc=%0d pc=%0d issued=%0d, want busy=%b done=%b valid=%b instr=%h npc=%0d pc=%0d issued=%0d",
               name, $time, act.busy, act.done, act.valid, act.instr, act.npc, act.pc, act.issued,
               e.busy, e.done, e.valid, e.instr, e.npc, e.pc, e.issued);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue what the next rising edge must produce.
  task automatic cyc(input bit r, input bit s, input bit st, input bit b, input int t);
    bit was_up;
    @(negedge clk);
    was_up    = rst_n;
    rst_n     = r;
    start     = s;
    stall     = st;
    br_taken  = b;
    br_target = AW'(t);
    model_step(r, s, st, b, t);
    exp_q.push_back(model_obs());
    if (was_up && !r) begin
      #1 compare("async_reset", dut_obs(), model_obs());
    end
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare("cycle", dut_obs(), e);
      end
    end
  end

  initial begin : driver
    rst_n = 1'b0; start = 0; stall = 0; br_taken = 0; br_target = '0;
    foreach (mem[i]) mem[i] = $urandom;
    model_reset();

    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 3);
    #1 compare("reset_hold", dut_obs(), model_obs());
    cyc(1, 0, 1, 1, 5);                        // idle ignores stall/branch
    cyc(1, 1, 0, 0, 0);                        // start
    for (int i = 0; i < 8; i++) cyc(1, i == 2, 0, 0, 0);  // stream, start ignored in run
    cyc(1, 0, 0, 0, 0);                        // enters done
    cyc(1, 0, 1, 1, 2);                        // done ignores stall/branch
    cyc(1, 1, 0, 0, 0);                        // restart
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0);  // stall at pc=4
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 2);                        // branch overrides stall at pc=6
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 200);                      // out-of-range target
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);                        // done on first unstalled edge
    cyc(1, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin          // drive issued into saturation
      for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 1, 0);
    end
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);                        // reset mid-run
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      bit r, s, st, b;
      int t;
      r  = ($urandom_range(0, 99) != 0);
      s  = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 7) == 0);
      t  = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 10));
      cyc(r, s, st, b, t);
    end

    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
